// File: rtl/cga_pkg.sv
// Shared types and sizes for the CGA video-RAM arbiter slice.
package cga_pkg;

    localparam int CGA_VRAM_AW = 19;
    localparam int FIFO_DEPTH  = 2;

    typedef enum logic [2:0] {
        IDLE,
        PIX_A,
        PIX_D,
        WR,
        WR_REC,
        RD_A,
        RD_D
    } vram_state_t;

endpackage

// File: rtl/cga_wr_fifo.sv
// Two-entry posted-write FIFO with an address-match port so CPU reads can
// be answered from queued writes.
module cga_wr_fifo
    import cga_pkg::*;
#(
    parameter int AW = CGA_VRAM_AW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic [AW-1:0] push_addr,
    input  logic [7:0]    push_data,
    input  logic          pop,
    input  logic [AW-1:0] match_addr,
    output logic          full,
    output logic          empty,
    output logic [AW-1:0] head_addr,
    output logic [7:0]    head_data,
    output logic          hit,
    output logic [7:0]    hit_data
);

    logic [AW-1:0] addr_mem [FIFO_DEPTH];
    logic [7:0]    data_mem [FIFO_DEPTH];
    logic          rd_ptr;
    logic [1:0]    count;
    logic          wr_ptr;
    logic          newest_ptr;
    logic          do_push;
    logic          do_pop;

    assign full       = (count == 2'd2);
    assign empty      = (count == 2'd0);
    assign wr_ptr     = rd_ptr ^ count[0];
    assign newest_ptr = full ? ~rd_ptr : rd_ptr;
    assign head_addr  = addr_mem[rd_ptr];
    assign head_data  = data_mem[rd_ptr];
    assign do_pop     = pop & ~empty;
    assign do_push    = push & (~full | do_pop);

    // The newest matching entry wins so a read sees the last posted write.
    always_comb begin
        hit      = 1'b0;
        hit_data = 8'h00;
        if (!empty && addr_mem[newest_ptr] == match_addr) begin
            hit      = 1'b1;
            hit_data = data_mem[newest_ptr];
        end else if (full && addr_mem[rd_ptr] == match_addr) begin
            hit      = 1'b1;
            hit_data = data_mem[rd_ptr];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr <= 1'b0;
            count  <= 2'd0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                addr_mem[i] <= '0;
                data_mem[i] <= 8'h00;
            end
        end else begin
            if (do_push) begin
                addr_mem[wr_ptr] <= push_addr;
                data_mem[wr_ptr] <= push_data;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/cga_vram_arbiter.sv
// Owns the video SRAM: fixed-latency pixel fetches, posted CPU writes and
// CPU reads inside sequencer-granted windows.
module cga_vram_arbiter
    import cga_pkg::*;
#(
    parameter int ADDR_WIDTH   = CGA_VRAM_AW,
    parameter int WR_PULSE     = 2,
    parameter int USE_BUS_WAIT = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] isa_addr,
    input  logic [7:0]            isa_din,
    input  logic                  isa_read,
    input  logic                  isa_write,
    output logic [7:0]            isa_dout,
    output logic                  isa_rdy,
    input  logic [ADDR_WIDTH-1:0] pixel_addr,
    input  logic                  pixel_read,
    output logic [7:0]            pixel_data,
    input  logic                  isa_op_enable,
    output logic [ADDR_WIDTH-1:0] ram_a,
    input  logic [7:0]            ram_d,
    output logic [7:0]            ram_dout,
    output logic                  ram_oe,
    output logic                  ram_we_l,
    output logic                  wr_overflow
);

    localparam logic [1:0] PULSE_LAST = 2'(WR_PULSE - 1);

    vram_state_t           state, state_n;
    logic [ADDR_WIDTH-1:0] ram_a_n;
    logic [7:0]            ram_dout_n, pixel_data_n, isa_dout_n;
    logic                  ram_oe_n, ram_we_l_n, wr_overflow_n;
    logic [1:0]            pulse_cnt, pulse_cnt_n;
    logic                  pix_hold, pix_hold_n;
    logic [ADDR_WIDTH-1:0] pix_hold_addr, pix_hold_addr_n;
    logic                  rd_pending, rd_pending_n;
    logic [ADDR_WIDTH-1:0] rd_addr, rd_addr_n;
    logic                  rd_wait, rd_wait_n;
    logic                  rd_done, rd_done_n;
    logic                  wr_stall, wr_stall_n;
    logic [ADDR_WIDTH-1:0] stall_addr, stall_addr_n;
    logic [7:0]            stall_data, stall_data_n;
    logic                  isa_read_q, isa_write_q;

    logic                  rd_edge, wr_edge, rd_miss, rd_req, pix_req, slot_free;
    logic                  fifo_push, fifo_pop, fifo_full, fifo_empty, fwd_hit;
    logic [ADDR_WIDTH-1:0] push_addr, head_addr, req_addr, pix_addr_sel;
    logic [7:0]            push_data, head_data, fwd_data;

    assign rd_edge      = isa_read & ~isa_read_q;
    assign wr_edge      = isa_write & ~isa_write_q;
    assign rd_miss      = rd_edge & ~fwd_hit;
    assign rd_req       = rd_pending | rd_miss;
    assign req_addr     = rd_pending ? rd_addr : isa_addr;
    assign pix_req      = pix_hold | pixel_read;
    assign pix_addr_sel = pix_hold ? pix_hold_addr : pixel_addr;
    assign isa_rdy      = (USE_BUS_WAIT != 0) ? ~(rd_wait | wr_stall) : 1'b1;

    cga_wr_fifo #(
        .AW(ADDR_WIDTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (fifo_push),
        .push_addr (push_addr),
        .push_data (push_data),
        .pop       (fifo_pop),
        .match_addr(isa_addr),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head_addr (head_addr),
        .head_data (head_data),
        .hit       (fwd_hit),
        .hit_data  (fwd_data)
    );

    // Request capture first, then the FSM, so an op started this cycle
    // overrides the pending flags the capture logic just raised.
    always_comb begin
        state_n         = state;
        ram_a_n         = ram_a;
        ram_dout_n      = ram_dout;
        ram_oe_n        = ram_oe;
        ram_we_l_n      = ram_we_l;
        pixel_data_n    = pixel_data;
        isa_dout_n      = isa_dout;
        wr_overflow_n   = wr_overflow;
        pulse_cnt_n     = pulse_cnt;
        pix_hold_n      = pix_hold;
        pix_hold_addr_n = pix_hold_addr;
        rd_pending_n    = rd_pending;
        rd_addr_n       = rd_addr;
        rd_wait_n       = rd_wait;
        rd_done_n       = (state == RD_D);
        wr_stall_n      = wr_stall;
        stall_addr_n    = stall_addr;
        stall_data_n    = stall_data;
        fifo_pop        = (state == WR_REC);
        fifo_push       = 1'b0;
        push_addr       = isa_addr;
        push_data       = isa_din;
        slot_free       = ~fifo_full | fifo_pop;

        if (wr_stall) begin
            if (slot_free) begin
                fifo_push  = 1'b1;
                push_addr  = stall_addr;
                push_data  = stall_data;
                wr_stall_n = 1'b0;
            end
        end else if (wr_edge) begin
            if (slot_free) begin
                fifo_push = 1'b1;
            end else if (USE_BUS_WAIT != 0) begin
                wr_stall_n   = 1'b1;
                stall_addr_n = isa_addr;
                stall_data_n = isa_din;
            end else begin
                wr_overflow_n = 1'b1;
            end
        end

        if (rd_done) begin
            rd_wait_n = 1'b0;
        end
        if (rd_edge && fwd_hit) begin
            isa_dout_n = fwd_data;
        end
        if (rd_miss) begin
            rd_pending_n = 1'b1;
            rd_addr_n    = isa_addr;
            rd_wait_n    = 1'b1;
        end

        if (pixel_read && state != IDLE) begin
            pix_hold_n      = 1'b1;
            pix_hold_addr_n = pixel_addr;
        end

        case (state)
            IDLE: begin
                ram_oe_n   = 1'b0;
                ram_we_l_n = 1'b1;
                if (pix_req) begin
                    state_n = PIX_A;
                    ram_a_n = pix_addr_sel;
                    if (pix_hold && pixel_read) begin
                        pix_hold_addr_n = pixel_addr;
                    end else begin
                        pix_hold_n = 1'b0;
                    end
                end else if (isa_op_enable) begin
                    if (!fifo_empty) begin
                        state_n     = WR;
                        ram_a_n     = head_addr;
                        ram_dout_n  = head_data;
                        ram_oe_n    = 1'b1;
                        ram_we_l_n  = 1'b0;
                        pulse_cnt_n = PULSE_LAST;
                    end else if (rd_req) begin
                        state_n      = RD_A;
                        ram_a_n      = req_addr;
                        rd_pending_n = 1'b0;
                    end
                end
            end
            PIX_A: state_n = PIX_D;
            PIX_D: begin
                pixel_data_n = ram_d;
                state_n      = IDLE;
            end
            WR: begin
                if (pulse_cnt == 2'd0) begin
                    state_n    = WR_REC;
                    ram_we_l_n = 1'b1;
                end else begin
                    pulse_cnt_n = pulse_cnt - 2'd1;
                end
            end
            WR_REC: begin
                ram_oe_n = 1'b0;
                state_n  = IDLE;
            end
            RD_A: state_n = RD_D;
            RD_D: begin
                isa_dout_n = ram_d;
                state_n    = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            ram_a         <= '0;
            ram_dout      <= 8'h00;
            ram_oe        <= 1'b0;
            ram_we_l      <= 1'b1;
            pixel_data    <= 8'h00;
            isa_dout      <= 8'h00;
            wr_overflow   <= 1'b0;
            pulse_cnt     <= 2'd0;
            pix_hold      <= 1'b0;
            pix_hold_addr <= '0;
            rd_pending    <= 1'b0;
            rd_addr       <= '0;
            rd_wait       <= 1'b0;
            rd_done       <= 1'b0;
            wr_stall      <= 1'b0;
            stall_addr    <= '0;
            stall_data    <= 8'h00;
            isa_read_q    <= 1'b0;
            isa_write_q   <= 1'b0;
        end else begin
            state         <= state_n;
            ram_a         <= ram_a_n;
            ram_dout      <= ram_dout_n;
            ram_oe        <= ram_oe_n;
            ram_we_l      <= ram_we_l_n;
            pixel_data    <= pixel_data_n;
            isa_dout      <= isa_dout_n;
            wr_overflow   <= wr_overflow_n;
            pulse_cnt     <= pulse_cnt_n;
            pix_hold      <= pix_hold_n;
            pix_hold_addr <= pix_hold_addr_n;
            rd_pending    <= rd_pending_n;
            rd_addr       <= rd_addr_n;
            rd_wait       <= rd_wait_n;
            rd_done       <= rd_done_n;
            wr_stall      <= wr_stall_n;
            stall_addr    <= stall_addr_n;
            stall_data    <= stall_data_n;
            isa_read_q    <= isa_read;
            isa_write_q   <= isa_write;
        end
    end

endmodule

// File: tb/tb_cga_vram_arbiter.sv
// Directed bench: one arbiter without bus wait (a_*) and one with (b_*),
// sharing stimulus, each with its own behavioural SRAM.
module tb_cga_vram_arbiter;

    localparam int AW = 19;

    logic          clk = 1'b0;
    logic          reset;
    logic [AW-1:0] isa_addr;
    logic [7:0]    isa_din;
    logic          isa_read, isa_write;
    logic [AW-1:0] pixel_addr;
    logic          pixel_read;
    logic          op_en;

    logic [7:0]    a_isa_dout, b_isa_dout, a_pixel_data, b_pixel_data;
    logic          a_isa_rdy, b_isa_rdy;
    logic [AW-1:0] a_ram_a, b_ram_a;
    logic [7:0]    a_ram_d, b_ram_d, a_ram_dout, b_ram_dout;
    logic          a_ram_oe, b_ram_oe, a_ram_we_l, b_ram_we_l;
    logic          a_wr_overflow, b_wr_overflow;

    bit [7:0]  a_mem [1024];
    bit        a_valid [1024];
    bit [7:0]  b_mem [1024];
    bit        b_valid [1024];
    bit [18:0] a_log_addr [16];
    bit [7:0]  a_log_data [16];
    int        a_we_cycles, a_oe_cycles, a_wr_events, b_rdy_low;
    logic      a_we_prev = 1'b1;

    int n_compared  = 0;
    int n_mismatched = 0;
    int snap0, snap1, snap2;

    always #5 clk = ~clk;

    function automatic logic [7:0] preset(input logic [9:0] idx);
        case (idx)
            10'h123: preset = 8'hA5;
            10'h124: preset = 8'hC3;
            10'h200: preset = 8'h11;
            10'h300: preset = 8'h5A;
            default: preset = 8'h00;
        endcase
    endfunction

    assign a_ram_d = a_valid[a_ram_a[9:0]] ? a_mem[a_ram_a[9:0]] : preset(a_ram_a[9:0]);
    assign b_ram_d = b_valid[b_ram_a[9:0]] ? b_mem[b_ram_a[9:0]] : preset(b_ram_a[9:0]);

    cga_vram_arbiter #(.ADDR_WIDTH(AW), .WR_PULSE(2), .USE_BUS_WAIT(0)) dut_a (
        .clk(clk), .reset(reset), .isa_addr(isa_addr), .isa_din(isa_din),
        .isa_read(isa_read), .isa_write(isa_write), .isa_dout(a_isa_dout),
        .isa_rdy(a_isa_rdy), .pixel_addr(pixel_addr), .pixel_read(pixel_read),
        .pixel_data(a_pixel_data), .isa_op_enable(op_en), .ram_a(a_ram_a),
        .ram_d(a_ram_d), .ram_dout(a_ram_dout), .ram_oe(a_ram_oe),
        .ram_we_l(a_ram_we_l), .wr_overflow(a_wr_overflow)
    );

    cga_vram_arbiter #(.ADDR_WIDTH(AW), .WR_PULSE(2), .USE_BUS_WAIT(1)) dut_b (
        .clk(clk), .reset(reset), .isa_addr(isa_addr), .isa_din(isa_din),
        .isa_read(isa_read), .isa_write(isa_write), .isa_dout(b_isa_dout),
        .isa_rdy(b_isa_rdy), .pixel_addr(pixel_addr), .pixel_read(pixel_read),
        .pixel_data(b_pixel_data), .isa_op_enable(op_en), .ram_a(b_ram_a),
        .ram_d(b_ram_d), .ram_dout(b_ram_dout), .ram_oe(b_ram_oe),
        .ram_we_l(b_ram_we_l), .wr_overflow(b_wr_overflow)
    );

    // SRAM models plus activity counters; the counters sample the value
    // each output held during the cycle that just ended.
    always @(posedge clk) begin
        a_we_prev <= a_ram_we_l;
        if (!a_ram_we_l) begin
            a_we_cycles              <= a_we_cycles + 1;
            a_mem[a_ram_a[9:0]]      <= a_ram_dout;
            a_valid[a_ram_a[9:0]]    <= 1'b1;
        end
        if (!a_ram_we_l && a_we_prev) begin
            a_log_addr[a_wr_events % 16] <= a_ram_a;
            a_log_data[a_wr_events % 16] <= a_ram_dout;
            a_wr_events                  <= a_wr_events + 1;
        end
        if (a_ram_oe) a_oe_cycles <= a_oe_cycles + 1;
        if (!b_ram_we_l) begin
            b_mem[b_ram_a[9:0]]   <= b_ram_dout;
            b_valid[b_ram_a[9:0]] <= 1'b1;
        end
        if (!b_isa_rdy) b_rdy_low <= b_rdy_low + 1;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        n_compared++;
        if (observed !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic rd, input logic wr,
                                 input logic [AW-1:0] addr, input logic [7:0] din);
        isa_read  = rd;
        isa_write = wr;
        isa_addr  = addr;
        isa_din   = din;
    endtask

    task automatic step(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic cpuWrite(input logic [AW-1:0] addr, input logic [7:0] din);
        applyStimulus(1'b0, 1'b1, addr, din);
        step();
        applyStimulus(1'b0, 1'b0, addr, din);
        step();
    endtask

    initial begin
        reset      = 1'b1;
        pixel_read = 1'b0;
        pixel_addr = '0;
        op_en      = 1'b0;
        applyStimulus(1'b0, 1'b0, '0, 8'h00);
        step(2);
        reset = 1'b0;
        step();

        $display("[TB] reset values");
        checkOutput("rst_we_l", a_ram_we_l, 1);
        checkOutput("rst_oe", a_ram_oe, 0);
        checkOutput("rst_ram_a", a_ram_a, 0);
        checkOutput("rst_ram_dout", a_ram_dout, 0);
        checkOutput("rst_pixel_data", a_pixel_data, 0);
        checkOutput("rst_isa_dout", a_isa_dout, 0);
        checkOutput("rst_rdy_b", b_isa_rdy, 1);
        checkOutput("rst_overflow", a_wr_overflow, 0);

        $display("[TB] pixel fetch");
        pixel_addr = 19'h00123;
        pixel_read = 1'b1;
        step();
        pixel_read = 1'b0;
        checkOutput("pix_ram_a", a_ram_a, 19'h00123);
        checkOutput("pix_data_early", a_pixel_data, 0);
        step(2);
        checkOutput("pix_data", a_pixel_data, 8'hA5);

        $display("[TB] single posted write");
        op_en = 1'b1;
        snap0 = a_we_cycles;
        snap1 = a_oe_cycles;
        snap2 = a_wr_events;
        cpuWrite(19'h00010, 8'h3C);
        checkOutput("wr_we_l_low", a_ram_we_l, 0);
        checkOutput("wr_oe_high", a_ram_oe, 1);
        checkOutput("wr_ram_a", a_ram_a, 19'h00010);
        checkOutput("wr_ram_dout", a_ram_dout, 8'h3C);
        step();
        checkOutput("wr_we_l_2nd", a_ram_we_l, 0);
        step();
        checkOutput("wr_rec_we_l", a_ram_we_l, 1);
        checkOutput("wr_rec_oe", a_ram_oe, 1);
        step();
        checkOutput("wr_done_oe", a_ram_oe, 0);
        step(3);
        checkOutput("wr_we_cycles", a_we_cycles - snap0, 2);
        checkOutput("wr_oe_cycles", a_oe_cycles - snap1, 3);
        checkOutput("wr_events", a_wr_events - snap2, 1);
        op_en = 1'b0;

        $display("[TB] FIFO full and overflow");
        snap0 = a_wr_events;
        cpuWrite(19'h00040, 8'h11);
        cpuWrite(19'h00041, 8'h22);
        checkOutput("ovf_two_queued", a_wr_overflow, 0);
        cpuWrite(19'h00042, 8'h33);
        checkOutput("ovf_third_drop", a_wr_overflow, 1);
        checkOutput("ovf_b_stall_rdy", b_isa_rdy, 0);
        checkOutput("ovf_no_drain", a_wr_events - snap0, 0);
        op_en = 1'b1;
        step(14);
        op_en = 1'b0;
        checkOutput("ovf_drain_count", a_wr_events - snap0, 2);
        checkOutput("ovf_drain0_addr", a_log_addr[snap0 % 16], 19'h00040);
        checkOutput("ovf_drain0_data", a_log_data[snap0 % 16], 8'h11);
        checkOutput("ovf_drain1_addr", a_log_addr[(snap0 + 1) % 16], 19'h00041);
        checkOutput("ovf_drain1_data", a_log_data[(snap0 + 1) % 16], 8'h22);
        checkOutput("ovf_b_no_flag", b_wr_overflow, 0);
        checkOutput("ovf_b_last_addr", b_ram_a, 19'h00042);
        checkOutput("ovf_b_rdy_back", b_isa_rdy, 1);

        $display("[TB] forwarded read");
        cpuWrite(19'h00200, 8'h77);
        snap0 = b_rdy_low;
        applyStimulus(1'b1, 1'b0, 19'h00200, 8'h00);
        step();
        checkOutput("fwd_dout_a", a_isa_dout, 8'h77);
        checkOutput("fwd_dout_b", b_isa_dout, 8'h77);
        step(3);
        applyStimulus(1'b0, 1'b0, 19'h00200, 8'h00);
        checkOutput("fwd_no_sram_a", a_ram_a, 19'h00041);
        checkOutput("fwd_rdy_b_low", b_rdy_low - snap0, 0);
        op_en = 1'b1;
        step(8);

        $display("[TB] read with pixel fetch during RD_D");
        snap0 = b_rdy_low;
        applyStimulus(1'b1, 1'b0, 19'h00300, 8'h00);
        step();
        checkOutput("rd_rdy_b_fell", b_isa_rdy, 0);
        checkOutput("rd_rdy_a_tied", a_isa_rdy, 1);
        step();
        pixel_addr = 19'h00124;
        pixel_read = 1'b1;
        step();
        pixel_read = 1'b0;
        checkOutput("rd_dout_b", b_isa_dout, 8'h5A);
        checkOutput("rd_dout_a", a_isa_dout, 8'h5A);
        checkOutput("rd_rdy_b_still", b_isa_rdy, 0);
        step();
        checkOutput("rd_pix_ram_a", b_ram_a, 19'h00124);
        checkOutput("rd_rdy_b_rose", b_isa_rdy, 1);
        step(2);
        checkOutput("rd_pix_data_b", b_pixel_data, 8'hC3);
        checkOutput("rd_pix_data_a", a_pixel_data, 8'hC3);
        checkOutput("rd_rdy_low_clks", b_rdy_low - snap0, 3);
        applyStimulus(1'b0, 1'b0, 19'h00300, 8'h00);
        step(2);

        $display("[TB] reset during write");
        cpuWrite(19'h00050, 8'h99);
        checkOutput("mid_wr_we_l", a_ram_we_l, 0);
        reset = 1'b1;
        #1;
        checkOutput("async_we_l_a", a_ram_we_l, 1);
        checkOutput("async_we_l_b", b_ram_we_l, 1);
        checkOutput("async_oe", a_ram_oe, 0);
        checkOutput("async_ram_a", a_ram_a, 0);
        checkOutput("async_pixel", a_pixel_data, 0);
        checkOutput("async_dout", a_isa_dout, 0);
        checkOutput("async_ovf", a_wr_overflow, 0);
        step(2);
        reset = 1'b0;
        snap0 = a_we_cycles;
        step(5);
        checkOutput("post_rst_empty", a_we_cycles - snap0, 0);
        checkOutput("post_rst_we_l", a_ram_we_l, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
